// File: rtl/legv8_isa_pkg.sv
// LEGv8 instruction-set definitions shared by the instruction loader and its field packer.
// Contents: instruction format codes, field widths and bit positions, opcode constants,
// the decoded-field bundle type and a format legality helper.
package legv8_isa_pkg;

    // Widths of the decoded field bundle
    localparam int unsigned WORD_W    = 32;
    localparam int unsigned FORMAT_W  = 3;
    localparam int unsigned OPCODE_W  = 11;
    localparam int unsigned REG_W     = 5;
    localparam int unsigned SHAMT_W   = 6;
    localparam int unsigned IMM_W     = 26;
    localparam int unsigned COUNT_W   = 7;

    // Opcode widths per format (opcodes arrive MSB-aligned in an 11-bit field)
    localparam int unsigned R_OP_W    = 11;
    localparam int unsigned I_OP_W    = 10;
    localparam int unsigned D_OP_W    = 11;
    localparam int unsigned CB_OP_W   = 8;
    localparam int unsigned B_OP_W    = 6;

    // Immediate widths per format
    localparam int unsigned I_IMM_W   = 12;
    localparam int unsigned D_IMM_W   = 9;
    localparam int unsigned CB_IMM_W  = 19;
    localparam int unsigned B_IMM_W   = 26;
    localparam int unsigned D_OP2_W   = 2;

    // Bit positions inside the 32-bit machine word
    localparam int unsigned RD_LSB     = 0;
    localparam int unsigned RN_LSB     = 5;
    localparam int unsigned SHAMT_LSB  = 10;
    localparam int unsigned RM_LSB     = 16;
    localparam int unsigned R_OP_LSB   = 21;
    localparam int unsigned I_IMM_LSB  = 10;
    localparam int unsigned I_OP_LSB   = 22;
    localparam int unsigned D_OP2_LSB  = 10;
    localparam int unsigned D_IMM_LSB  = 12;
    localparam int unsigned D_OP_LSB   = 21;
    localparam int unsigned CB_RT_LSB  = 0;
    localparam int unsigned CB_IMM_LSB = 5;
    localparam int unsigned CB_OP_LSB  = 24;
    localparam int unsigned B_IMM_LSB  = 0;
    localparam int unsigned B_OP_LSB   = 26;

    // Instruction format codes; 5..7 are illegal
    typedef enum logic [FORMAT_W-1:0] {
        FMT_R  = 3'd0,
        FMT_I  = 3'd1,
        FMT_D  = 3'd2,
        FMT_B  = 3'd3,
        FMT_CB = 3'd4
    } format_e;

    // Opcode constants, MSB-aligned to 11 bits
    localparam logic [OPCODE_W-1:0] OP_ADD  = 11'b100_0101_1000;
    localparam logic [OPCODE_W-1:0] OP_ADDI = 11'b100_1000_1000;
    localparam logic [OPCODE_W-1:0] OP_LDUR = 11'b111_1100_0010;
    localparam logic [OPCODE_W-1:0] OP_STUR = 11'b111_1100_0000;
    localparam logic [OPCODE_W-1:0] OP_B    = 11'b000_1010_0000;
    localparam logic [OPCODE_W-1:0] OP_CBZ  = 11'b101_1010_0000;
    localparam logic [OPCODE_W-1:0] OP_CBNZ = 11'b101_1010_1000;

    // Decoded instruction bundle as presented by the host
    typedef struct packed {
        logic [FORMAT_W-1:0] format;
        logic [OPCODE_W-1:0] opcode;
        logic [REG_W-1:0]    rd;
        logic [REG_W-1:0]    rn;
        logic [REG_W-1:0]    rm;
        logic [SHAMT_W-1:0]  shamt;
        logic [IMM_W-1:0]    imm;
    } instr_fields_t;

    // True for the five encodable formats
    function automatic logic isLegalFormat(input logic [FORMAT_W-1:0] fmt);
        return fmt <= FORMAT_W'(FMT_CB);
    endfunction

endpackage

// File: rtl/instr_field_packer.sv
// Combinational packer: decoded LEGv8 fields -> 32-bit machine word.
// Ports:
//   fields     decoded bundle (format, opcode, registers, shamt, immediate)
//   word       packed R/I/D/B/CB instruction; zero for illegal formats
//   rangeError immediate does not fit its field (only with IMM_RANGE_CHECK_EN)
// Build option: IMM_RANGE_CHECK_EN enables immediate range checking; otherwise the
// immediate is truncated to the field width and rangeError is tied low.
module instr_field_packer
    import legv8_isa_pkg::*;
(
    input  instr_fields_t       fields,
    output logic [WORD_W-1:0]   word,
    output logic                rangeError
);

    // Field concatenation per format
    always_comb begin
        word = '0;
        case (fields.format)
            FMT_R:  word = {fields.opcode[OPCODE_W-1 -: R_OP_W], fields.rm, fields.shamt,
                            fields.rn, fields.rd};
            FMT_I:  word = {fields.opcode[OPCODE_W-1 -: I_OP_W], fields.imm[I_IMM_W-1:0],
                            fields.rn, fields.rd};
            FMT_D:  word = {fields.opcode[OPCODE_W-1 -: D_OP_W], fields.imm[D_IMM_W-1:0],
                            fields.shamt[D_OP2_W-1:0], fields.rn, fields.rd};
            FMT_B:  word = {fields.opcode[OPCODE_W-1 -: B_OP_W], fields.imm[B_IMM_W-1:0]};
            FMT_CB: word = {fields.opcode[OPCODE_W-1 -: CB_OP_W], fields.imm[CB_IMM_W-1:0],
                            fields.rd};
            default: word = '0;
        endcase
    end

`ifdef IMM_RANGE_CHECK_EN
    // Upper immediate bits must be zero (I) or copies of the field sign bit (D/CB)
    logic dHighOnes, dHighZeros, cbHighOnes, cbHighZeros;

    always_comb begin
        dHighOnes   = &fields.imm[IMM_W-1:D_IMM_W-1];
        dHighZeros  = ~(|fields.imm[IMM_W-1:D_IMM_W-1]);
        cbHighOnes  = &fields.imm[IMM_W-1:CB_IMM_W-1];
        cbHighZeros = ~(|fields.imm[IMM_W-1:CB_IMM_W-1]);
        rangeError  = 1'b0;
        case (fields.format)
            FMT_I:  rangeError = |fields.imm[IMM_W-1:I_IMM_W];
            FMT_D:  rangeError = ~(dHighOnes | dHighZeros);
            FMT_CB: rangeError = ~(cbHighOnes | cbHighZeros);
            default: rangeError = 1'b0;   // B spans the whole immediate
        endcase
    end
`else
    assign rangeError = 1'b0;
`endif

endmodule

// File: rtl/instruction_loader.sv
// Instruction-cache program loader: accepts decoded field bundles over valid/ready,
// packs them into LEGv8 words and writes them at consecutive word addresses from a
// base address, one program load per start pulse.
// Ports:
//   clock, resetN            clock (rising edge), asynchronous active-low reset
//   start, baseAddress       begin a load at baseAddress (bits [1:0] forced to 0)
//   inValid/inReady/inLast   bundle handshake; inLast marks the final instruction
//   inFormat..inImm          decoded fields of the bundle
//   wrEnable/wrAddress/wrData instruction-cache write port (registered)
//   busy, done, wordCount    load status; done pulses with the final write
//   errorFlag                sticky illegal-format / range error, cleared by start
// Build option: IMM_RANGE_CHECK_EN (see instr_field_packer) rejects out-of-range immediates.
module instruction_loader
    import legv8_isa_pkg::*;
#(
    parameter int unsigned DEPTH  = 64,
    parameter int unsigned ADDR_W = 32
) (
    input  logic                 clock,
    input  logic                 resetN,
    input  logic                 start,
    input  logic [ADDR_W-1:0]    baseAddress,
    input  logic                 inValid,
    output logic                 inReady,
    input  logic                 inLast,
    input  logic [FORMAT_W-1:0]  inFormat,
    input  logic [OPCODE_W-1:0]  inOpcode,
    input  logic [REG_W-1:0]     inRd,
    input  logic [REG_W-1:0]     inRn,
    input  logic [REG_W-1:0]     inRm,
    input  logic [SHAMT_W-1:0]   inShamt,
    input  logic [IMM_W-1:0]     inImm,
    output logic                 wrEnable,
    output logic [ADDR_W-1:0]    wrAddress,
    output logic [WORD_W-1:0]    wrData,
    output logic                 busy,
    output logic                 done,
    output logic [COUNT_W-1:0]   wordCount,
    output logic                 errorFlag
);

    localparam logic [COUNT_W-1:0] DEPTH_C      = COUNT_W'(DEPTH);
    localparam logic [COUNT_W-1:0] LAST_ACCEPT  = COUNT_W'(DEPTH - 1);
    localparam logic [ADDR_W-1:0]  ALIGN_MASK   = ~ADDR_W'(3);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        LOADING = 2'd1,
        DRAIN   = 2'd2
    } state_e;

    state_e               state, stateNext;
    logic [ADDR_W-1:0]    baseReg, baseNext;
    logic [COUNT_W-1:0]   acceptCount, acceptNext;
    logic                 inReadyNext, wrEnableNext, busyNext, doneNext, errorFlagNext;
    logic [ADDR_W-1:0]    wrAddressNext;
    logic [WORD_W-1:0]    wrDataNext;
    logic [COUNT_W-1:0]   wordCountNext;

    instr_fields_t        fields;
    logic [WORD_W-1:0]    packedWord;
    logic                 rangeError;
    logic                 handshake;
    logic                 rejected;

    // Field bundle feeding the packer
    assign fields = '{format: inFormat, opcode: inOpcode, rd: inRd, rn: inRn,
                      rm: inRm, shamt: inShamt, imm: inImm};

    instr_field_packer uPacker (
        .fields     (fields),
        .word       (packedWord),
        .rangeError (rangeError)
    );

    // inReady is only ever high in LOADING, so this is the accepted-bundle strobe
    assign handshake = inValid && inReady;
    assign rejected  = !isLegalFormat(inFormat) || rangeError;

    // Next-state and next-output logic
    always_comb begin
        stateNext     = state;
        baseNext      = baseReg;
        acceptNext    = acceptCount;
        inReadyNext   = inReady;
        wrEnableNext  = 1'b0;
        wrAddressNext = wrAddress;
        wrDataNext    = wrData;
        busyNext      = busy;
        doneNext      = 1'b0;
        wordCountNext = wordCount;
        errorFlagNext = errorFlag;

        case (state)
            IDLE: begin
                if (start) begin
                    stateNext     = LOADING;
                    baseNext      = baseAddress & ALIGN_MASK;
                    acceptNext    = '0;
                    wordCountNext = '0;
                    errorFlagNext = 1'b0;
                    inReadyNext   = 1'b1;
                    busyNext      = 1'b1;
                end
            end

            LOADING: begin
                if (handshake) begin
                    acceptNext = acceptCount + COUNT_W'(1);
                    if (rejected) begin
                        // Rejected bundles consume a slot but leave the address untouched
                        errorFlagNext = 1'b1;
                    end else begin
                        wrEnableNext  = 1'b1;
                        wrAddressNext = baseReg + (ADDR_W'(wordCount) << 2);
                        wrDataNext    = packedWord;
                        if (wordCount != DEPTH_C) begin
                            wordCountNext = wordCount + COUNT_W'(1);
                        end
                    end
                    if (inLast || (acceptCount == LAST_ACCEPT)) begin
                        // Final write lands in the DRAIN cycle together with done
                        stateNext   = DRAIN;
                        inReadyNext = 1'b0;
                        busyNext    = 1'b0;
                        doneNext    = 1'b1;
                    end
                end
            end

            DRAIN: begin
                stateNext = IDLE;
            end

            default: begin
                stateNext   = IDLE;
                inReadyNext = 1'b0;
                busyNext    = 1'b0;
            end
        endcase
    end

    // State and registered outputs
    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            state       <= IDLE;
            baseReg     <= '0;
            acceptCount <= '0;
            inReady     <= 1'b0;
            wrEnable    <= 1'b0;
            wrAddress   <= '0;
            wrData      <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            wordCount   <= '0;
            errorFlag   <= 1'b0;
        end else begin
            state       <= stateNext;
            baseReg     <= baseNext;
            acceptCount <= acceptNext;
            inReady     <= inReadyNext;
            wrEnable    <= wrEnableNext;
            wrAddress   <= wrAddressNext;
            wrData      <= wrDataNext;
            busy        <= busyNext;
            done        <= doneNext;
            wordCount   <= wordCountNext;
            errorFlag   <= errorFlagNext;
        end
    end

endmodule

// File: tb/tb_instruction_loader.sv
// Self-checking bench for instruction_loader: table of known encodings, hand-written
// corner sequences, and randomized loads checked against an arithmetic reference model.
module tb_instruction_loader;
    import legv8_isa_pkg::*;

    localparam int unsigned DEPTH  = 64;
    localparam int unsigned ADDR_W = 32;
`ifdef IMM_RANGE_CHECK_EN
    localparam bit RANGE_CHK = 1'b1;
`else
    localparam bit RANGE_CHK = 1'b0;
`endif

    logic                clock = 1'b0;
    logic                resetN = 1'b1;
    logic                start = 1'b0;
    logic [ADDR_W-1:0]   baseAddress = '0;
    logic                inValid = 1'b0;
    logic                inReady;
    logic                inLast = 1'b0;
    logic [2:0]          inFormat = '0;
    logic [10:0]         inOpcode = '0;
    logic [4:0]          inRd = '0, inRn = '0, inRm = '0;
    logic [5:0]          inShamt = '0;
    logic [25:0]         inImm = '0;
    logic                wrEnable;
    logic [ADDR_W-1:0]   wrAddress;
    logic [31:0]         wrData;
    logic                busy, done, errorFlag;
    logic [6:0]          wordCount;

    always #5 clock = ~clock;

    instruction_loader #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
        .clock(clock), .resetN(resetN), .start(start), .baseAddress(baseAddress),
        .inValid(inValid), .inReady(inReady), .inLast(inLast), .inFormat(inFormat),
        .inOpcode(inOpcode), .inRd(inRd), .inRn(inRn), .inRm(inRm), .inShamt(inShamt),
        .inImm(inImm), .wrEnable(wrEnable), .wrAddress(wrAddress), .wrData(wrData),
        .busy(busy), .done(done), .wordCount(wordCount), .errorFlag(errorFlag)
    );

    int checks = 0;
    int errors = 0;

    // Reference model state for the current load
    logic [31:0] mBase;
    int          mCount, mAccepted, mWrites;
    bit          mErr;
    int          ldWr0, ldDone0;

    // Observed write strobes and done pulses
    int wrSeen = 0;
    int doneSeen = 0;
    always @(negedge clock) begin
        if (wrEnable) wrSeen++;
        if (done) doneSeen++;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Encoding from the instruction-format field layouts, by plain arithmetic
    function automatic logic [31:0] refWord(input int fmt, op, rd, rn, rm, sh, imm);
        longint w;
        case (fmt)
            0: w = longint'(op) * 2097152 + longint'(rm) * 65536 + longint'(sh) * 1024
                   + longint'(rn) * 32 + longint'(rd);
            1: w = longint'(op / 2) * 4194304 + longint'(imm % 4096) * 1024
                   + longint'(rn) * 32 + longint'(rd);
            2: w = longint'(op) * 2097152 + longint'(imm % 512) * 4096
                   + longint'(sh % 4) * 1024 + longint'(rn) * 32 + longint'(rd);
            3: w = longint'(op / 32) * 67108864 + longint'(imm % 67108864);
            4: w = longint'(op / 8) * 16777216 + longint'(imm % 524288) * 32 + longint'(rd);
            default: w = 0;
        endcase
        return 32'(w);
    endfunction

    function automatic bit refFits(input int fmt, input int imm);
        int s;
        s = (imm >= 33554432) ? imm - 67108864 : imm;
        case (fmt)
            1: return imm < 4096;
            2: return (s >= -256) && (s <= 255);
            4: return (s >= -262144) && (s <= 262143);
            default: return 1'b1;
        endcase
    endfunction

    task automatic doReset();
        @(negedge clock);
        resetN = 1'b0; start = 1'b0; inValid = 1'b0;
        repeat (2) @(negedge clock);
        check("reset_inReady", inReady, 0);
        check("reset_wrEnable", wrEnable, 0);
        check("reset_busy", busy, 0);
        check("reset_done", done, 0);
        check("reset_errorFlag", errorFlag, 0);
        check("reset_wordCount", wordCount, 0);
        check("reset_wrAddress", wrAddress, 0);
        check("reset_wrData", wrData, 0);
        resetN = 1'b1;
    endtask

    task automatic doStart(input logic [31:0] base);
        @(negedge clock);
        start = 1'b1; baseAddress = base; inValid = 1'b0;
        @(negedge clock);
        start = 1'b0;
        mBase = base & 32'hFFFF_FFFC;
        mCount = 0; mAccepted = 0; mWrites = 0; mErr = 1'b0;
        ldWr0 = wrSeen; ldDone0 = doneSeen;
        check("start_busy", busy, 1);
        check("start_inReady", inReady, 1);
        check("start_wordCount", wordCount, 0);
        check("start_errorFlag", errorFlag, 0);
    endtask

    // Present one bundle, wait (bounded) for its handshake, then check the write cycle
    task automatic sendBundle(input int fmt, op, rd, rn, rm, sh, imm, input bit last,
                              input int gap);
        bit got, legal, expDrain;
        logic [31:0] expAddr, expWord;
        repeat (gap) begin
            @(negedge clock);
            inValid = 1'b0; start = 1'b0;
        end
        @(negedge clock);
        start = 1'b0; inValid = 1'b1; inLast = last;
        inFormat = 3'(fmt); inOpcode = 11'(op); inRd = 5'(rd); inRn = 5'(rn);
        inRm = 5'(rm); inShamt = 6'(sh); inImm = 26'(imm);
        got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            if (inReady === 1'b1) got = 1'b1;
            else @(negedge clock);
        end
        checks++;
        if (!got) begin
            errors++;
            $display("FAIL handshake_timeout: got inReady=%0b expected 1", inReady);
            return;
        end
        @(posedge clock);
        #1;
        legal = (fmt <= 4) && (!RANGE_CHK || refFits(fmt, imm));
        expAddr = mBase + 32'(4 * mCount);
        expWord = refWord(fmt, op, rd, rn, rm, sh, imm);
        mAccepted++;
        if (legal) begin
            if (mCount < DEPTH) mCount++;
            mWrites++;
        end else begin
            mErr = 1'b1;
        end
        expDrain = last || (mAccepted == DEPTH);
        check("wr_enable", wrEnable, legal);
        if (legal) begin
            check("wr_address", wrAddress, expAddr);
            check("wr_data", wrData, expWord);
        end
        check("error_flag", errorFlag, mErr);
        check("word_count", wordCount, mCount);
        check("done_pulse", done, expDrain);
        check("in_ready_after", inReady, !expDrain);
    endtask

    task automatic finishLoad();
        @(negedge clock);
        inValid = 1'b0;
        repeat (2) @(negedge clock);
        check("end_busy", busy, 0);
        check("end_inReady", inReady, 0);
        check("end_done", done, 0);
        check("end_wrEnable", wrEnable, 0);
        check("end_wordCount", wordCount, mCount);
        check("end_errorFlag", errorFlag, mErr);
        check("end_write_count", wrSeen - ldWr0, mWrites);
        check("end_done_count", doneSeen - ldDone0, 1);
    endtask

    typedef struct {
        int fmt; int op; int rd; int rn; int rm; int sh; int imm;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs[7];

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int wrHold;
        vecs[0] = '{0, OP_ADD,  1, 2, 3, 0, 0,          32'h8B03_0041};
        vecs[1] = '{1, OP_ADDI, 9, 9, 0, 0, 1,          32'h9100_0529};
        vecs[2] = '{2, OP_LDUR, 0, 1, 0, 0, 8,          32'hF840_8020};
        vecs[3] = '{3, OP_B,    0, 0, 0, 0, 'h3FF_FFFF, 32'h17FF_FFFF};
        vecs[4] = '{4, OP_CBZ,  5, 0, 0, 0, 2,          32'hB400_0045};
        vecs[5] = '{2, OP_STUR, 2, 3, 0, 0, 'h3FF_FFFC, 32'hF81F_C062};
        vecs[6] = '{4, OP_CBNZ, 7, 0, 0, 0, 'h3FF_FFFD, 32'hB5FF_FFA7};

        #1 resetN = 1'b0;
        doReset();

        // Known encodings, one single-word load each
        foreach (vecs[k]) begin
            doStart(32'h0000_0101);
            sendBundle(vecs[k].fmt, vecs[k].op, vecs[k].rd, vecs[k].rn, vecs[k].rm,
                       vecs[k].sh, vecs[k].imm, 1'b1, 0);
            check("table_word", wrData, vecs[k].exp);
            check("table_addr", wrAddress, 32'h100);
            finishLoad();
        end

        // Four back-to-back bundles
        doStart(32'h100);
        sendBundle(1, OP_ADDI, 9, 9, 0, 0, 1, 1'b0, 0);
        sendBundle(2, OP_LDUR, 0, 1, 0, 0, 8, 1'b0, 0);
        sendBundle(3, OP_B, 0, 0, 0, 0, 'h3FF_FFFF, 1'b0, 0);
        sendBundle(4, OP_CBZ, 5, 0, 0, 0, 2, 1'b1, 0);
        check("b2b_last_addr", wrAddress, 32'h10C);
        check("b2b_last_data", wrData, 32'hB400_0045);
        finishLoad();
        check("b2b_word_count", wordCount, 4);

        // Illegal format mid-stream, plus a start pulse that must be ignored
        doStart(32'h200);
        sendBundle(0, OP_ADD, 1, 2, 3, 0, 0, 1'b0, 0);
        @(negedge clock);
        start = 1'b1; baseAddress = 32'h900; inValid = 1'b0;
        sendBundle(6, OP_ADD, 1, 2, 3, 0, 0, 1'b0, 0);
        check("illegal_error", errorFlag, 1);
        sendBundle(1, OP_ADDI, 9, 9, 0, 0, 1, 1'b1, 0);
        check("illegal_next_addr", wrAddress, 32'h204);
        finishLoad();

        // Immediate out of range for ADDI
        doStart(32'h300);
        sendBundle(1, OP_ADDI, 9, 9, 0, 0, 4096, 1'b1, 0);
`ifdef IMM_RANGE_CHECK_EN
        check("imm4096_error", errorFlag, 1);
        check("imm4096_nowrite", wrEnable, 0);
`else
        check("imm4096_data", wrData, 32'h9100_0129);
`endif
        finishLoad();

        // DEPTH bundles without inLast, with address wrap; the extra bundle is refused
        doStart(32'hFFFF_FF80);
        for (int i = 0; i < DEPTH; i++)
            sendBundle(0, OP_ADD, i % 32, (i + 1) % 32, (i + 2) % 32, i % 64, 0, 1'b0, 0);
        @(negedge clock);
        inValid = 1'b1; inLast = 1'b0;
        repeat (4) begin
            @(negedge clock);
            check("depth_extra_ready", inReady, 0);
        end
        finishLoad();
        check("depth_write_total", wrSeen - ldWr0, DEPTH);

        // Reset in the middle of a load
        doStart(32'h400);
        sendBundle(0, OP_ADD, 1, 2, 3, 0, 0, 1'b0, 0);
        #3 resetN = 1'b0;
        #1;
        check("midreset_wrEnable", wrEnable, 0);
        check("midreset_inReady", inReady, 0);
        check("midreset_busy", busy, 0);
        check("midreset_wordCount", wordCount, 0);
        check("midreset_wrAddress", wrAddress, 0);
        check("midreset_wrData", wrData, 0);
        wrHold = wrSeen;
        repeat (3) @(negedge clock);
        resetN = 1'b1;
        repeat (3) @(negedge clock);
        check("postreset_busy", busy, 0);
        check("postreset_inReady", inReady, 0);
        check("postreset_nowrite", wrSeen - wrHold, 0);
        inValid = 1'b0;
        doStart(32'h500);
        sendBundle(1, OP_ADDI, 9, 9, 0, 0, 1, 1'b0, 0);
        sendBundle(4, OP_CBZ, 5, 0, 0, 0, 2, 1'b1, 1);
        finishLoad();

        // Randomized loads against the model
        for (int n = 0; n < 20; n++) begin
            int len;
            len = $urandom_range(1, 8);
            doStart($urandom());
            for (int j = 0; j < len; j++) begin
                int fmt, imm;
                fmt = ($urandom_range(0, 9) < 8) ? $urandom_range(0, 4) : $urandom_range(5, 7);
                imm = ($urandom_range(0, 1) == 1) ? $urandom_range(0, 300)
                                                  : int'($urandom() % 67108864);
                sendBundle(fmt, $urandom_range(0, 2047), $urandom_range(0, 31),
                           $urandom_range(0, 31), $urandom_range(0, 31),
                           $urandom_range(0, 63), imm, j == len - 1, $urandom_range(0, 2));
            end
            finishLoad();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/instruction_loader.md
Name: instruction_loader

Overview:
- Writer side of the instruction-cache fetch path; the processor's PC/InstructionCache only read 32-bit LEGv8 words.
- Accepts decoded instruction fields from a bench or host over a valid/ready handshake and packs them into R/I/D/B/CB machine words.
- Writes each word into the instruction cache write port at consecutive byte addresses (stride 4, matching PC increment).
- Runs before the core is released; one program load per start pulse.

Parameters:
DEPTH, 64, maximum words per load (capacity of the instruction cache)
ADDR_W, 32, byte-address width of the write port

Ports:
clock  in  1  processor clock, rising edge
resetN  in  1  asynchronous active-low reset
start  in  1  one-cycle pulse: begin a load at baseAddress
baseAddress  in  ADDR_W  byte address of the first word; bits [1:0] ignored (treated as 0)
inValid  in  1  field bundle valid
inReady  out  1  loader can accept a bundle
inLast  in  1  current bundle is the final instruction
inFormat  in  3  0=R, 1=I, 2=D, 3=B, 4=CB, 5..7 illegal
inOpcode  in  11  MSB-aligned opcode: R/D use [10:0], I uses [10:1], CB uses [10:3], B uses [10:5]
inRd  in  5  Rd/Rt
inRn  in  5  Rn
inRm  in  5  Rm (R only)
inShamt  in  6  shamt (R); D op field = inShamt[1:0]
inImm  in  26  immediate: I unsigned 12b, D signed 9b, CB signed 19b, B signed 26b (word offsets)
wrEnable  out  1  instruction-cache write strobe
wrAddress  out  ADDR_W  byte address of the write
wrData  out  32  encoded instruction
busy  out  1  state is LOADING
done  out  1  one-cycle pulse at load completion
wordCount  out  7  words written in the current/last load
errorFlag  out  1  sticky: illegal format (or range error, see option); cleared by start

Behaviour:
- Reset (async, resetN=0): state IDLE; inReady, wrEnable, busy, done, errorFlag = 0; wordCount = 0; wrAddress = 0; wrData = 0. Cache contents are untouched. Reset mid-load abandons the load with no further writes.
- States:
  - IDLE: start -> LOADING; latch base, wordCount = 0, errorFlag = 0.
  - LOADING: inReady=1. A handshake (inValid && inReady) at edge N produces wrEnable=1 for exactly the following cycle (N..N+1) with wrData = encoded word and wrAddress = base + 4*wordCount. wordCount increments at the same edge as the write.
  - LOADING exits to DRAIN when the accepted bundle has inLast=1, or when it is accepted bundle number DEPTH. inReady drops in the cycle after that acceptance.
  - DRAIN: issue the final write; assert done in the same cycle; next edge -> IDLE.
- start is ignored outside IDLE. inValid outside LOADING is ignored (inReady=0).
- Encodings:
  - R = op[10:0], Rm, shamt, Rn, Rd
  - I = op[10:1], imm[11:0], Rn, Rd
  - D = op[10:0], imm[8:0], shamt[1:0], Rn, Rd
  - B = op[10:5], imm[25:0]
  - CB = op[10:3], imm[18:0], Rd
- Illegal format: handshake completes, errorFlag is set, and no write occurs. The bundle still counts toward DEPTH and inLast, but wordCount is not incremented.
- wordCount saturates at DEPTH. Address arithmetic wraps modulo 2^ADDR_W.

Optional Feature:
IMM_RANGE_CHECK_EN
- Defined: an immediate that does not fit its field is rejected. I rejects any nonzero bit in [25:12]. D/CB/B reject anything that is not a correct sign-extension of the field width. A rejected bundle sets errorFlag and is handled exactly like an illegal format (no write).
- Undefined: the immediate is silently truncated to the field width and written.

Decomposition:
- Shared package legv8_isa_pkg:
  - format codes
  - field widths and bit positions
  - opcode constants ADD, ADDI, LDUR, STUR, B, CBZ, CBNZ
- Sub-module instr_field_packer: combinational fields -> 32-bit word, plus a rangeError output. It sits inside the loader's single register stage.

Test Plan:
- base=0x100: R ADD op=10001011000 Rd1 Rn2 Rm3 -> wrEnable one cycle after handshake, wrAddress=0x100, wrData=0x8B030041.
- Four back-to-back bundles with inValid held high: I ADDI Rd9 Rn9 imm1, then D LDUR Rt0 Rn1 imm8, then B imm=-1, then CB CBZ Rt5 imm2 (inLast). Required writes:
  - 0x91000529 @0x100
  - 0xF8408020 @0x104
  - 0x17FFFFFF @0x108
  - 0xB4000045 @0x10C
  - done coincides with the last write; wordCount=4.
- Format=6 mid-stream -> errorFlag=1, no write for that bundle, subsequent addresses not advanced.
- DEPTH+1 bundles with inLast never set -> exactly DEPTH writes, inReady low after the DEPTH-th acceptance, done pulses once.
- ADDI imm=4096:
  - with IMM_RANGE_CHECK_EN -> errorFlag=1, no write.
  - without -> write 0x91000129.
- resetN low two cycles after start, after one accepted bundle -> all outputs 0 asynchronously, no further wrEnable, state IDLE; a new start loads normally.
